// File: rtl/clock_ctrl_pkg.sv
// rtl/clock_ctrl_pkg.sv - shared state codes, digit constants and field limits for the clock controller
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_e;

    localparam logic [3:0] BLANK_DIGIT = 4'hF;

    localparam logic [3:0] HR_MAX_T = 4'd2;
    localparam logic [3:0] HR_MAX_O = 4'd3;
    localparam logic [3:0] MS_MAX_T = 4'd5;
    localparam logic [3:0] MS_MAX_O = 4'd9;

    // Mode button walks the states in code order and wraps back to RUN.
    function automatic state_e next_state(input state_e s);
        return state_e'(s + 2'd1);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter that wraps to 00 after MAX_T/MAX_O
module bcd_mod_counter #(
    parameter logic [3:0] MAX_T = 4'd5,
    parameter logic [3:0] MAX_O = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       at_max;

    assign at_max = (tens_q == MAX_T) && (ones_q == MAX_O);
    assign wrap   = inc && at_max;
    assign tens   = tens_q;
    assign ones   = ones_q;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (inc) begin
            if (at_max) begin
                tens_d = 4'd0;
                ones_d = 4'd0;
            end else if (ones_q == 4'd9) begin
                tens_d = tens_q + 4'd1;
                ones_d = 4'd0;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - HH:MM:SS timekeeper with mode/up time-set FSM and blinking edit field
module clock_time_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic [3:0] d4,
    output logic [3:0] d5,
    output logic [1:0] mode,
    output logic       tick_1hz
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // [0],[1] synchronise the async pin; [2] is the previous synced value for edge detection.
    logic [2:0] mode_sync_q, up_sync_q;
    logic       mode_edge, up_edge, up_set;

    state_e     state_q, state_d;
    logic       in_run;

    logic [PW-1:0] presc_q, presc_d;
    logic          presc_wrap;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blank_q, blank_d;

    logic       sec_inc, min_inc, hr_inc;
    logic       sec_wrap, min_wrap, hr_wrap_unused;
    logic [3:0] sec_t, sec_o, min_t, min_o, hr_t, hr_o;

    logic [3:0] d0_q, d1_q, d2_q, d3_q, d4_q, d5_q;
    logic [1:0] mode_q;
    logic       tick_q;
    logic       hide_hr, hide_min, hide_sec;

    assign mode_edge = mode_sync_q[1] & ~mode_sync_q[2];
    assign up_edge   = up_sync_q[1] & ~up_sync_q[2];
    assign in_run    = (state_q == ST_RUN);
    assign up_set    = up_edge & ~mode_edge & ~in_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sync_q <= 3'b000;
            up_sync_q   <= 3'b000;
        end else begin
            mode_sync_q <= {mode_sync_q[1:0], btn_mode};
            up_sync_q   <= {up_sync_q[1:0], btn_up};
        end
    end

    always_comb begin
        state_d = state_q;
        if (mode_edge) begin
            state_d = next_state(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Held at zero while editing, so RUN always restarts a full second.
    assign presc_wrap = in_run && (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (!in_run || presc_wrap) begin
            presc_d = '0;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blank_d     = blank_q;
        if (mode_edge || up_edge) begin
            blink_cnt_d = '0;
            blank_d     = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blank_d     = ~blank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    // RUN chains carries; edit states steer the up edge to one field only.
    assign sec_inc = in_run ? presc_wrap : (up_set && state_q == ST_SET_SEC);
    assign min_inc = in_run ? sec_wrap   : (up_set && state_q == ST_SET_MIN);
    assign hr_inc  = in_run ? min_wrap   : (up_set && state_q == ST_SET_HR);

    bcd_mod_counter #(.MAX_T(MS_MAX_T), .MAX_O(MS_MAX_O)) u_sec (
        .clk(clk), .rst_n(rst_n), .inc(sec_inc),
        .tens(sec_t), .ones(sec_o), .wrap(sec_wrap)
    );

    bcd_mod_counter #(.MAX_T(MS_MAX_T), .MAX_O(MS_MAX_O)) u_min (
        .clk(clk), .rst_n(rst_n), .inc(min_inc),
        .tens(min_t), .ones(min_o), .wrap(min_wrap)
    );

    bcd_mod_counter #(.MAX_T(HR_MAX_T), .MAX_O(HR_MAX_O)) u_hr (
        .clk(clk), .rst_n(rst_n), .inc(hr_inc),
        .tens(hr_t), .ones(hr_o), .wrap(hr_wrap_unused)
    );

    assign hide_hr  = blank_q && (state_q == ST_SET_HR);
    assign hide_min = blank_q && (state_q == ST_SET_MIN);
    assign hide_sec = blank_q && (state_q == ST_SET_SEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q   <= 4'd0;
            d1_q   <= 4'd0;
            d2_q   <= 4'd0;
            d3_q   <= 4'd0;
            d4_q   <= 4'd0;
            d5_q   <= 4'd0;
            mode_q <= 2'd0;
            tick_q <= 1'b0;
        end else begin
            d0_q   <= hide_sec ? BLANK_DIGIT : sec_o;
            d1_q   <= hide_sec ? BLANK_DIGIT : sec_t;
            d2_q   <= hide_min ? BLANK_DIGIT : min_o;
            d3_q   <= hide_min ? BLANK_DIGIT : min_t;
            d4_q   <= hide_hr  ? BLANK_DIGIT : hr_o;
            d5_q   <= hide_hr  ? BLANK_DIGIT : hr_t;
            mode_q <= state_q;
            tick_q <= presc_wrap;
        end
    end

    assign d0       = d0_q;
    assign d1       = d1_q;
    assign d2       = d2_q;
    assign d3       = d3_q;
    assign d4       = d4_q;
    assign d5       = d5_q;
    assign mode     = mode_q;
    assign tick_1hz = tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - directed table-driven bench for clock_time_ctrl
module tb_clock_time_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic [3:0] d0, d1, d2, d3, d4, d5;
    logic [1:0] mode;
    logic       tick_1hz;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        m;
        logic        u;
        int          reps;
        logic [1:0]  emode;
        logic [23:0] edig;
    } vec_t;

    vec_t tbl[15];

    clock_time_ctrl #(.TICK_DIV(4), .BLINK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
        .mode(mode), .tick_1hz(tick_1hz)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] digits();
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [1:0] emode, input logic [23:0] edig,
                           input logic etick);
        chk({name, ".mode"}, 32'(mode), 32'(emode));
        chk({name, ".digits"}, 32'(digits()), 32'(edig));
        chk({name, ".tick"}, 32'(tick_1hz), 32'(etick));
    endtask

    // Raise pins, then sample one update after the edge has acted (visible blink phase).
    task automatic press(input logic m, input logic u);
        @(posedge clk); #1;
        btn_mode = m;
        btn_up   = u;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic release_btns();
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            for (int i = 0; i < tbl[r].reps; i++) begin
                press(tbl[r].m, tbl[r].u);
                if (i == tbl[r].reps - 1) begin
                    chk($sformatf("row%0d.mode", r), 32'(mode), 32'(tbl[r].emode));
                    chk($sformatf("row%0d.digits", r), 32'(digits()), 32'(tbl[r].edig));
                end
                release_btns();
            end
        end
    endtask

    // Reset, then release with btn_mode already high so SET_HR is reached before any tick.
    task automatic reset_into_set_hr();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        btn_mode = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_all("enter_hr", 2'd1, 24'h000000, 1'b0);
        release_btns();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 23, 2'd1, 24'h230000};
        tbl[1]  = '{1'b0, 1'b1,  1, 2'd1, 24'h000000};
        tbl[2]  = '{1'b0, 1'b1, 23, 2'd1, 24'h230000};
        tbl[3]  = '{1'b1, 1'b0,  1, 2'd2, 24'h230000};
        tbl[4]  = '{1'b0, 1'b1, 59, 2'd2, 24'h235900};
        tbl[5]  = '{1'b0, 1'b1,  1, 2'd2, 24'h230000};
        tbl[6]  = '{1'b0, 1'b1, 59, 2'd2, 24'h235900};
        tbl[7]  = '{1'b1, 1'b1,  1, 2'd3, 24'h235900};
        tbl[8]  = '{1'b0, 1'b1, 59, 2'd3, 24'h235959};
        tbl[9]  = '{1'b0, 1'b1,  2, 2'd1, 24'h020000};
        tbl[10] = '{1'b0, 1'b1,  1, 2'd1, 24'h030000};
        tbl[11] = '{1'b1, 1'b0,  1, 2'd2, 24'h030000};
        tbl[12] = '{1'b0, 1'b1,  2, 2'd2, 24'h030200};
        tbl[13] = '{1'b1, 1'b0,  1, 2'd3, 24'h030200};
        tbl[14] = '{1'b0, 1'b1,  4, 2'd3, 24'h030204};

        // Reset state, then free-running ticks every 4 clk.
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 2'd0, 24'h000000, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk($sformatf("run_tick_k%0d", k), 32'(tick_1hz), 32'(k % 4 == 0));
            chk($sformatf("run_d0_k%0d", k), 32'(digits()), 32'((k - 1) / 4));
        end

        // Set 23:59:59 including hour/minute wraps and a simultaneous mode+up press.
        reset_into_set_hr();
        run_rows(0, 8);

        // Back to RUN: first tick 4 clk later rolls everything to 00:00:00 at once.
        press(1'b1, 1'b0);
        chk_all("to_run_p4", 2'd0, 24'h235959, 1'b0);
        btn_mode = 1'b0;
        for (int p = 5; p <= 8; p++) begin
            @(posedge clk); #1;
            chk_all($sformatf("rollover_p%0d", p), 2'd0,
                    (p == 8) ? 24'h000000 : 24'h235959, p == 7);
        end

        // Blink of the hours field while idle in SET_HR.
        reset_into_set_hr();
        run_rows(9, 9);
        for (int j = 8; j <= 15; j++) begin
            @(posedge clk); #1;
            chk_all($sformatf("blink_p%0d", j), 2'd1,
                    ((((j - 4) / 2) % 2) == 1) ? 24'hFF0000 : 24'h020000, 1'b0);
        end
        run_rows(10, 14);

        // Asynchronous reset in the middle of SET_SEC.
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 2'd0, 24'h000000, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            chk_all($sformatf("post_reset_k%0d", k), 2'd0,
                    (k == 5) ? 24'h000001 : 24'h000000, k == 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
